fc_core_scheduler: RTL and testbench

Sequences a bank of NUM_CORE fully_connected_core instances through one fully connected layer. Each pass of the cores computes NUM_CORE output neurons, so the layer is split into groups of NUM_CORE outputs. For each group the block clears the accumulators, streams every input node (broadcast) together with one weight per core from memory, waits for the accumulation to settle, then serialises the NUM_CORE results onto a ready/valid output stream. It sits between the layer-level top controller and the node/weight BRAMs and the core array.

---
 rtl/fc_pkg.sv | 20 ++
 rtl/fc_result_serializer.sv | 57 +++++
 rtl/fc_core_scheduler.sv | 173 +++++++++++++++++
 tb/tb_fc_core_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants for the fully connected layer scheduler: FSM encoding,
// pipeline depths and the core result width.
package fc_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  // Last valid beat plus the core accumulator register update.
  localparam int DRAIN_CYCLES = 2;
  localparam int MEM_LATENCY  = 1;
  localparam int RES_MULT     = 4;

  function automatic int res_width(input int in_w);
    return RES_MULT * in_w;
  endfunction

endpackage

// File: rtl/fc_result_serializer.sv
// Walks the valid lanes of the core result vector one beat at a time on a
// ready/valid stream and flags the final beat back to the scheduler FSM.
module fc_result_serializer
  import fc_pkg::*;
#(
  parameter int NUM_CORE      = 32,
  parameter int IN_DATA_WIDTH = 16,
  parameter int CNT_WIDTH     = 12,
  parameter int LCW           = 6
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        i_active,
  input  logic [NUM_CORE*res_width(IN_DATA_WIDTH)-1:0] i_result,
  input  logic [CNT_WIDTH-1:0]                        i_base_idx,
  input  logic [LCW-1:0]                              i_lane_cnt,
  input  logic                                        i_res_ready,
  output logic                                        o_res_valid,
  output logic [CNT_WIDTH-1:0]                        o_res_idx,
  output logic [res_width(IN_DATA_WIDTH)-1:0]         o_res_data,
  output logic                                        o_last
);

  localparam int RES_W = res_width(IN_DATA_WIDTH);
  localparam int LW    = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

  logic [LW-1:0]           lane_q, lane_d;
  logic                    fire;
  logic                    last_lane;
  logic signed [RES_W-1:0] lane_data;

  assign fire      = i_active && i_res_ready;
  assign last_lane = (LCW'(lane_q) + LCW'(1)) == i_lane_cnt;
  assign lane_data = i_result[int'(lane_q)*RES_W +: RES_W];

  always_comb begin
    lane_d = lane_q;
    if (fire) begin
      lane_d = last_lane ? '0 : lane_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  // Lane pointer only moves on a completed beat, so data/idx hold under stall.
  assign o_res_valid = i_active;
  assign o_res_idx   = i_active ? i_base_idx + CNT_WIDTH'(lane_q) : '0;
  assign o_res_data  = i_active ? lane_data : '0;
  assign o_last      = fire && last_lane;

endmodule

// File: rtl/fc_core_scheduler.sv
// Sequences a bank of MAC cores through one fully connected layer, one group
// of NUM_CORE output neurons at a time, and streams the results out.
module fc_core_scheduler
  import fc_pkg::*;
#(
  parameter int NUM_CORE      = 32,
  parameter int IN_DATA_WIDTH = 16,
  parameter int CNT_WIDTH     = 12,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          i_start,
  input  logic [CNT_WIDTH-1:0]                          i_num_in,
  input  logic [CNT_WIDTH-1:0]                          i_num_out,
  output logic                                          o_idle,
  output logic                                          o_done,
  output logic                                          o_node_ce,
  output logic [ADDR_WIDTH-1:0]                         o_node_addr,
  input  logic [IN_DATA_WIDTH-1:0]                      i_node_data,
  output logic                                          o_wegt_ce,
  output logic [ADDR_WIDTH-1:0]                         o_wegt_addr,
  input  logic [NUM_CORE*IN_DATA_WIDTH-1:0]             i_wegt_data,
  output logic                                          o_core_run,
  output logic                                          o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]                      o_core_node,
  output logic [NUM_CORE*IN_DATA_WIDTH-1:0]             o_core_wegt,
  input  logic [NUM_CORE*res_width(IN_DATA_WIDTH)-1:0]  i_core_result,
  output logic                                          o_res_valid,
  output logic [CNT_WIDTH-1:0]                          o_res_idx,
  output logic [res_width(IN_DATA_WIDTH)-1:0]           o_res_data,
  input  logic                                          i_res_ready
);

  localparam int LCW = $clog2(NUM_CORE + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  logic [2:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   num_in_q, num_in_d;
  logic [CNT_WIDTH-1:0]   num_out_q, num_out_d;
  logic [CNT_WIDTH-1:0]   feed_cnt_q, feed_cnt_d;
  logic [CNT_WIDTH-1:0]   out_base_q, out_base_d;
  logic [ADDR_WIDTH-1:0]  wbase_q, wbase_d;
  logic [DCW-1:0]         drain_q, drain_d;
  logic                   done_q, done_d;
  logic [MEM_LATENCY-1:0] vld_q;

  logic                   feeding;
  logic                   ser_last;
  logic [CNT_WIDTH-1:0]   remaining;
  logic [CNT_WIDTH-1:0]   last_feed;
  logic [LCW-1:0]         lane_cnt;

  assign feeding   = (state_q == ST_FEED);
  assign remaining = num_out_q - out_base_q;
  assign last_feed = num_in_q - CNT_WIDTH'(1);
  assign lane_cnt  = (remaining >= CNT_WIDTH'(NUM_CORE)) ? LCW'(NUM_CORE) : LCW'(remaining);

  always_comb begin
    state_d    = state_q;
    num_in_d   = num_in_q;
    num_out_d  = num_out_q;
    feed_cnt_d = feed_cnt_q;
    out_base_d = out_base_q;
    wbase_d    = wbase_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_in_d   = i_num_in;
          num_out_d  = i_num_out;
          out_base_d = '0;
          wbase_d    = '0;
          // Empty layer: acknowledge without touching memory or cores.
          if (i_num_in == '0 || i_num_out == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        feed_cnt_d = '0;
        state_d    = ST_FEED;
      end
      ST_FEED: begin
        feed_cnt_d = feed_cnt_q + CNT_WIDTH'(1);
        if (feed_cnt_q == last_feed) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (ser_last) begin
          // Weight base advances by num_in per group, i.e. g*num_in mod 2^ADDR_WIDTH.
          if (remaining > CNT_WIDTH'(NUM_CORE)) begin
            out_base_d = out_base_q + CNT_WIDTH'(NUM_CORE);
            wbase_d    = wbase_q + ADDR_WIDTH'(num_in_q);
            state_d    = ST_CLEAR;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      num_in_q   <= '0;
      num_out_q  <= '0;
      feed_cnt_q <= '0;
      out_base_q <= '0;
      wbase_q    <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_in_q   <= num_in_d;
      num_out_q  <= num_out_d;
      feed_cnt_q <= feed_cnt_d;
      out_base_q <= out_base_d;
      wbase_q    <= wbase_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      vld_q      <= MEM_LATENCY'({vld_q, feeding});
    end
  end

  assign o_idle      = (state_q == ST_IDLE);
  assign o_done      = done_q;
  assign o_node_ce   = feeding;
  assign o_wegt_ce   = feeding;
  assign o_node_addr = feeding ? ADDR_WIDTH'(feed_cnt_q) : '0;
  assign o_wegt_addr = feeding ? wbase_q + ADDR_WIDTH'(feed_cnt_q) : '0;
  assign o_core_run  = (state_q == ST_CLEAR);

  // Memory output registers supply the data; valid is delayed to line up with them.
  assign o_core_valid = vld_q[MEM_LATENCY-1];
  assign o_core_node  = o_core_valid ? i_node_data : '0;
  assign o_core_wegt  = o_core_valid ? i_wegt_data : '0;

  fc_result_serializer #(
    .NUM_CORE      (NUM_CORE),
    .IN_DATA_WIDTH (IN_DATA_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH),
    .LCW           (LCW)
  ) u_serializer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_active    (state_q == ST_OUT),
    .i_result    (i_core_result),
    .i_base_idx  (out_base_q),
    .i_lane_cnt  (lane_cnt),
    .i_res_ready (i_res_ready),
    .o_res_valid (o_res_valid),
    .o_res_idx   (o_res_idx),
    .o_res_data  (o_res_data),
    .o_last      (ser_last)
  );

endmodule

// File: tb/tb_fc_core_scheduler.sv
// Directed bench for fc_core_scheduler with NUM_CORE=4: behavioural node and
// weight memories, four accumulating cores and a result stream monitor.
module tb_fc_core_scheduler;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic [11:0]   i_num_in, i_num_out;
  logic          o_idle, o_done;
  logic          o_node_ce, o_wegt_ce;
  logic [15:0]   o_node_addr, o_wegt_addr;
  logic [15:0]   node_data;
  logic [63:0]   wegt_data;
  logic          o_core_run, o_core_valid;
  logic [15:0]   o_core_node;
  logic [63:0]   o_core_wegt;
  logic [255:0]  core_result;
  logic          o_res_valid;
  logic [11:0]   o_res_idx;
  logic [63:0]   o_res_data;
  logic          i_res_ready;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [15:0] node_mem [0:63];
  logic [63:0] wegt_mem [0:63];
  logic signed [63:0] acc [4];

  int run_cnt = 0, done_cnt = 0, ce_cnt = 0, valid_cyc = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  int run_cyc_q [$];
  logic [11:0] bidx_q [$];
  logic [63:0] bdat_q [$];
  logic [15:0] waddr_q [$];
  logic [15:0] naddr_q [$];

  always #5 clk = ~clk;

  fc_core_scheduler #(
    .NUM_CORE(4), .IN_DATA_WIDTH(16), .CNT_WIDTH(12), .ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .i_num_in(i_num_in), .i_num_out(i_num_out),
    .o_idle(o_idle), .o_done(o_done),
    .o_node_ce(o_node_ce), .o_node_addr(o_node_addr), .i_node_data(node_data),
    .o_wegt_ce(o_wegt_ce), .o_wegt_addr(o_wegt_addr), .i_wegt_data(wegt_data),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid),
    .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
    .i_core_result(core_result),
    .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res_data(o_res_data),
    .i_res_ready(i_res_ready)
  );

  function automatic logic signed [63:0] sx(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

  always_ff @(posedge clk) cyc_n <= cyc_n + 1;

  always_ff @(posedge clk) begin
    if (o_node_ce) node_data <= node_mem[o_node_addr[5:0]];
    if (o_wegt_ce) wegt_data <= wegt_mem[o_wegt_addr[5:0]];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (o_core_run) acc[k] <= '0;
      else if (o_core_valid) acc[k] <= acc[k] + sx(o_core_node) * sx(o_core_wegt[k*16 +: 16]);
    end
  end

  assign core_result = {acc[3], acc[2], acc[1], acc[0]};

  // Stream/event monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (o_core_run) begin run_cnt++; run_cyc_q.push_back(cyc_n); end
      if (o_done) begin done_cnt++; done_cyc = cyc_n; end
      if (o_node_ce) begin
        ce_cnt++;
        waddr_q.push_back(o_wegt_addr);
        naddr_q.push_back(o_node_addr);
      end
      if (o_res_valid) valid_cyc++;
      if (o_res_valid && i_res_ready) begin
        bidx_q.push_back(o_res_idx);
        bdat_q.push_back(o_res_data);
        last_beat_cyc = cyc_n;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int nin, input int nout);
    i_num_in  = 12'(nin);
    i_num_out = 12'(nout);
    i_start   = 1'b1;
    cyc();
    i_start   = 1'b0;
    i_num_in  = '0;
    i_num_out = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 64'(o_done), 64'(1));
    cyc();
  endtask

  task automatic clear_mems();
    for (int a = 0; a < 64; a++) begin
      node_mem[a] = '0;
      wegt_mem[a] = '0;
    end
  endtask

  // Core k sees weight k on every input, nodes {1,2,3}: results 6*k.
  task automatic load_t1();
    clear_mems();
    for (int a = 0; a < 3; a++) begin
      node_mem[a] = 16'(a + 1);
      wegt_mem[a] = {16'd3, 16'd2, 16'd1, 16'd0};
    end
  endtask

  task automatic chk_t1_beats(input string tag, input int base);
    chk({tag, "_nbeats"}, 64'(bidx_q.size() - base), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (base + k < bidx_q.size()) begin
        chk($sformatf("%s_idx%0d", tag, k), 64'(bidx_q[base+k]), 64'(k));
        chk($sformatf("%s_dat%0d", tag, k), bdat_q[base+k], 64'(6 * k));
      end
    end
  endtask

  initial begin
    int bb, rb, db, cb, wb, vb, b, n;
    logic hold;
    reset_n = 1'b0; i_start = 1'b0; i_num_in = '0; i_num_out = '0; i_res_ready = 1'b1;
    load_t1();
    repeat (3) cyc();

    chk("rst_idle",      64'(o_idle),       64'(1));
    chk("rst_done",      64'(o_done),       64'(0));
    chk("rst_node_ce",   64'(o_node_ce),    64'(0));
    chk("rst_core_run",  64'(o_core_run),   64'(0));
    chk("rst_core_vld",  64'(o_core_valid), 64'(0));
    chk("rst_res_valid", 64'(o_res_valid),  64'(0));
    chk("rst_res_data",  o_res_data,        64'(0));
    reset_n = 1'b1;
    repeat (2) cyc();

    // Single group, results {0,6,12,18}.
    bb = bidx_q.size(); rb = run_cnt; db = done_cnt;
    start_layer(3, 4);
    wait_done("t1_done", 40);
    chk_t1_beats("t1", bb);
    chk("t1_latency", 64'(last_beat_cyc - run_cyc_q[rb]), 64'(9));
    chk("t1_done_lat", 64'(done_cyc - last_beat_cyc), 64'(1));
    chk("t1_runs", 64'(run_cnt - rb), 64'(1));
    chk("t1_dones", 64'(done_cnt - db), 64'(1));

    // Two groups, second group partial.
    clear_mems();
    node_mem[0] = 16'd1; node_mem[1] = 16'd2;
    for (int a = 0; a < 4; a++)
      wegt_mem[a] = {16'(4*a+3), 16'(4*a+2), 16'(4*a+1), 16'(4*a)};
    bb = bidx_q.size(); rb = run_cnt; wb = waddr_q.size();
    start_layer(2, 6);
    wait_done("t2_done", 60);
    chk("t2_nbeats", 64'(bidx_q.size() - bb), 64'(6));
    for (int k = 0; k < 6; k++) begin
      if (bb + k < bidx_q.size()) begin
        chk($sformatf("t2_idx%0d", k), 64'(bidx_q[bb+k]), 64'(k));
        chk($sformatf("t2_dat%0d", k), bdat_q[bb+k], 64'((k < 4) ? 3*k + 8 : 32 + 3*(k-4)));
      end
    end
    chk("t2_nreads", 64'(waddr_q.size() - wb), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (wb + k < waddr_q.size()) begin
        chk($sformatf("t2_waddr%0d", k), 64'(waddr_q[wb+k]), 64'(k));
        chk($sformatf("t2_naddr%0d", k), 64'(naddr_q[wb+k]), 64'(k % 2));
      end
    end
    chk("t2_runs", 64'(run_cnt - rb), 64'(2));
    chk("t2_latency", 64'(last_beat_cyc - run_cyc_q[rb]), 64'(15));

    // Negative node times max positive weight, sign-extended result.
    clear_mems();
    node_mem[0] = 16'hFFFD; node_mem[1] = 16'hFFFD;
    wegt_mem[0] = {4{16'h7FFF}}; wegt_mem[1] = {4{16'h7FFF}};
    bb = bidx_q.size();
    start_layer(2, 4);
    wait_done("t3_done", 40);
    chk("t3_nbeats", 64'(bidx_q.size() - bb), 64'(4));
    for (int k = 0; k < 4; k++)
      if (bb + k < bdat_q.size())
        chk($sformatf("t3_dat%0d", k), bdat_q[bb+k], 64'hFFFF_FFFF_FFFD_0006);

    // Backpressure: ready alternates 0/1 while the stream is valid.
    load_t1();
    bb = bidx_q.size(); vb = valid_cyc;
    i_res_ready = 1'b0;
    start_layer(3, 4);
    b = 0; n = 0; hold = 1'b0;
    while (!o_done && n < 60) begin
      if (o_res_valid) begin
        chk($sformatf("t4_idx_b%0d_h%0d", b, hold), 64'(o_res_idx), 64'(b));
        chk($sformatf("t4_dat_b%0d_h%0d", b, hold), o_res_data, 64'(6 * b));
        if (!hold) begin
          i_res_ready = 1'b0;
          hold = 1'b1;
        end else begin
          i_res_ready = 1'b1;
          hold = 1'b0;
          b++;
        end
      end else begin
        i_res_ready = 1'b0;
      end
      cyc();
      n++;
    end
    chk("t4_done", 64'(o_done), 64'(1));
    i_res_ready = 1'b1;
    cyc();
    chk_t1_beats("t4", bb);
    chk("t4_out_cycles", 64'(valid_cyc - vb), 64'(8));

    // Empty layer: immediate done, no memory or core activity.
    cb = ce_cnt; rb = run_cnt;
    start_layer(0, 4);
    chk("t5_done", 64'(o_done), 64'(1));
    chk("t5_idle", 64'(o_idle), 64'(1));
    cyc();
    chk("t5_done_pulse", 64'(o_done), 64'(0));
    repeat (3) cyc();
    chk("t5_no_ce", 64'(ce_cnt - cb), 64'(0));
    chk("t5_no_run", 64'(run_cnt - rb), 64'(0));

    // Start pulse during FEED is ignored.
    bb = bidx_q.size(); rb = run_cnt; db = done_cnt;
    start_layer(3, 4);
    cyc();
    i_start = 1'b1; i_num_in = 12'd5; i_num_out = 12'd1;
    cyc();
    i_start = 1'b0; i_num_in = '0; i_num_out = '0;
    wait_done("t5b_done", 40);
    chk_t1_beats("t5b", bb);
    chk("t5b_runs", 64'(run_cnt - rb), 64'(1));
    chk("t5b_dones", 64'(done_cnt - db), 64'(1));

    // Asynchronous reset in the middle of FEED aborts the layer.
    db = done_cnt;
    start_layer(3, 4);
    repeat (2) cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_idle",      64'(o_idle),       64'(1));
    chk("t6_node_ce",   64'(o_node_ce),    64'(0));
    chk("t6_node_addr", 64'(o_node_addr),  64'(0));
    chk("t6_core_vld",  64'(o_core_valid), 64'(0));
    chk("t6_res_valid", 64'(o_res_valid),  64'(0));
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("t6_no_done", 64'(done_cnt - db), 64'(0));
    bb = bidx_q.size();
    start_layer(3, 4);
    wait_done("t6_rerun_done", 40);
    chk_t1_beats("t6", bb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
